// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bypass interface: decode presents its operands and destination,
// the hazard unit answers with per-operand bypass selects, stall and regfile write port.
interface hazard_fwd_unit_if #(
    parameter int ADDR_SIZE = 5
);
    logic                 D_valid;
    logic [ADDR_SIZE-1:0] D_ra;
    logic [ADDR_SIZE-1:0] D_rb;
    logic                 D_use_ra;
    logic                 D_use_rb;
    logic [ADDR_SIZE-1:0] D_rd;
    logic                 D_we;
    logic                 D_ld;
    logic                 EX_flush;
    logic                 MEM_stall;
    logic [1:0]           EX_D_bp;
    logic [1:0]           MEM_D_bp;
    logic [1:0]           WB_D_bp;
    logic                 D_stall;
    logic                 WB_we;
    logic [ADDR_SIZE-1:0] WB_rd;

    modport master (
        output D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld,
        output EX_flush, MEM_stall,
        input  EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, WB_we, WB_rd
    );

    modport slave (
        input  D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld,
        input  EX_flush, MEM_stall,
        output EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, WB_we, WB_rd
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Shadow pipeline of EX/MEM/WB destination tags driving decode bypass selects,
// load-use stall detection, the regfile write port and a load-use stall counter.
module hazard_fwd_unit #(
    parameter int ADDR_SIZE = 5,
    parameter int CNT_BITS  = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_fwd_unit_if.slave    bus,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef struct packed {
        logic                 v;
        logic [ADDR_SIZE-1:0] rd;
        logic                 we;
        logic                 ld;
    } ex_slot_t;

    // The load flag only changes behaviour while the producer sits in EX,
    // so the later slots carry just the tag.
    typedef struct packed {
        logic                 v;
        logic [ADDR_SIZE-1:0] rd;
        logic                 we;
    } tag_slot_t;

    ex_slot_t            ex_q, ex_d;
    tag_slot_t           mem_q, mem_d;
    tag_slot_t           wb_q, wb_d;
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

    logic m_ex_ra, m_ex_rb, m_mem_ra, m_mem_rb, m_wb_ra, m_wb_rb;
    logic d_stall;
    logic [1:0] ex_bp, mem_bp, wb_bp;

    function automatic logic src_hit(
        input logic                 use_s,
        input logic [ADDR_SIZE-1:0] src,
        input logic                 v,
        input logic                 we,
        input logic [ADDR_SIZE-1:0] rd
    );
        return bus.D_valid & use_s & (src != '0) & v & we & (rd == src);
    endfunction

    always_comb begin
        m_ex_ra  = src_hit(bus.D_use_ra, bus.D_ra, ex_q.v,  ex_q.we,  ex_q.rd);
        m_ex_rb  = src_hit(bus.D_use_rb, bus.D_rb, ex_q.v,  ex_q.we,  ex_q.rd);
        m_mem_ra = src_hit(bus.D_use_ra, bus.D_ra, mem_q.v, mem_q.we, mem_q.rd);
        m_mem_rb = src_hit(bus.D_use_rb, bus.D_rb, mem_q.v, mem_q.we, mem_q.rd);
        m_wb_ra  = src_hit(bus.D_use_ra, bus.D_ra, wb_q.v,  wb_q.we,  wb_q.rd);
        m_wb_rb  = src_hit(bus.D_use_rb, bus.D_rb, wb_q.v,  wb_q.we,  wb_q.rd);

        // An EX hit on a load blocks the younger stages too: their value is stale.
        ex_bp  = {m_ex_ra & ~ex_q.ld, m_ex_rb & ~ex_q.ld};
        mem_bp = {m_mem_ra & ~m_ex_ra, m_mem_rb & ~m_ex_rb};
        wb_bp  = {m_wb_ra & ~m_ex_ra & ~m_mem_ra, m_wb_rb & ~m_ex_rb & ~m_mem_rb};

        d_stall = (m_ex_ra | m_ex_rb) & ex_q.ld & ~bus.EX_flush & ~bus.MEM_stall;
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q + CNT_BITS'(d_stall);

        if (!bus.MEM_stall) begin
            mem_d = '{v: ex_q.v, rd: ex_q.rd, we: ex_q.we};
            wb_d  = mem_q;
            if (bus.EX_flush || d_stall) begin
                ex_d = '0;
            end else begin
                ex_d = '{v:  bus.D_valid,
                         rd: bus.D_rd,
                         we: bus.D_we & bus.D_valid,
                         ld: bus.D_ld & bus.D_valid};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.EX_D_bp  = ex_bp;
    assign bus.MEM_D_bp = mem_bp;
    assign bus.WB_D_bp  = wb_bp;
    assign bus.D_stall  = d_stall;
    assign bus.WB_we    = wb_q.v & wb_q.we & (wb_q.rd != '0);
    assign bus.WB_rd    = wb_q.rd;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboarded bench for hazard_fwd_unit: each driven decode cycle queues the
// hand-derived expected outputs, which a negedge monitor pops and compares.
module tb_hazard_fwd_unit;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] stall_cnt;

    hazard_fwd_unit_if #(.ADDR_SIZE(AW)) bus ();

    hazard_fwd_unit #(.ADDR_SIZE(AW), .CNT_BITS(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [1:0]    ex_bp;
        logic [1:0]    mem_bp;
        logic [1:0]    wb_bp;
        logic          stall;
        logic          wb_we;
        logic [AW-1:0] wb_rd;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val({e.tag, ".ex_bp"},  64'(bus.EX_D_bp),  64'(e.ex_bp));
            check_val({e.tag, ".mem_bp"}, 64'(bus.MEM_D_bp), 64'(e.mem_bp));
            check_val({e.tag, ".wb_bp"},  64'(bus.WB_D_bp),  64'(e.wb_bp));
            check_val({e.tag, ".stall"},  64'(bus.D_stall),  64'(e.stall));
            check_val({e.tag, ".wb_we"},  64'(bus.WB_we),    64'(e.wb_we));
            check_val({e.tag, ".wb_rd"},  64'(bus.WB_rd),    64'(e.wb_rd));
            check_val({e.tag, ".cnt"},    64'(stall_cnt),    64'(e.cnt));
        end
    end

    // One pipeline cycle: drive decode inputs just after the edge, queue expectations.
    task automatic step(
        input string tag, input logic r,
        input logic v, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
        input logic ura, input logic urb, input logic [AW-1:0] rd,
        input logic we, input logic ld, input logic fl, input logic ms,
        input logic [1:0] eex, input logic [1:0] emem, input logic [1:0] ewb,
        input logic est, input logic ewe, input logic [AW-1:0] erd, input logic [CW-1:0] ecnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.D_valid   = v;
        bus.D_ra      = ra;
        bus.D_rb      = rb;
        bus.D_use_ra  = ura;
        bus.D_use_rb  = urb;
        bus.D_rd      = rd;
        bus.D_we      = we;
        bus.D_ld      = ld;
        bus.EX_flush  = fl;
        bus.MEM_stall = ms;
        e = '{tag: tag, ex_bp: eex, mem_bp: emem, wb_bp: ewb,
              stall: est, wb_we: ewe, wb_rd: erd, cnt: ecnt};
        sb.push_back(e);
    endtask

    task automatic nop(input string tag, input logic ewe, input logic [AW-1:0] erd, input logic [CW-1:0] ecnt);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, ewe, erd, ecnt);
    endtask

    initial begin
        bus.D_valid = 0; bus.D_ra = 0; bus.D_rb = 0; bus.D_use_ra = 0; bus.D_use_rb = 0;
        bus.D_rd = 0; bus.D_we = 0; bus.D_ld = 0; bus.EX_flush = 0; bus.MEM_stall = 0;

        //    tag        r  v  ra rb ua ub rd we ld fl ms  ex     mem    wb     st we rd cnt
        step("reset",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);

        // back-to-back ALU dependency
        step("t1_add3",  0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        step("t1_use3",  0, 1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0);
        nop("t1_n0", 0, 0, 0);
        nop("t1_wb3", 1, 3, 0);
        nop("t1_wb4", 1, 4, 0);

        // load-use: one stall then MEM bypass
        step("t2_ld5",   0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        step("t2_stall", 0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
        step("t2_membp", 0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 1);
        nop("t2_wb5", 1, 5, 1);
        nop("t2_bub", 0, 0, 1);
        nop("t2_wb6", 1, 6, 1);

        // r7 in EX, MEM and WB simultaneously, then draining priority
        step("t3_w7a",   0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        step("t3_w7b",   0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        step("t3_w7c",   0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        step("t3_exprio",0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1, 7, 1);
        step("t3_memprio",0,1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 1, 7, 1);
        step("t3_wbbp",  0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 1, 7, 1);
        nop("t3_n0", 0, 0, 1);
        nop("t3_n1", 0, 0, 1);

        // r0 is never forwarded nor written
        step("t4_wr0",   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        step("t4_rd0",   0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        nop("t4_n0", 0, 0, 1);
        nop("t4_wb_r0", 0, 0, 1);
        nop("t4_n1", 0, 0, 1);

        // flush beats load-use stall; squashed consumer never reaches WB
        step("t5_ld2",   0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        step("t5_flush", 0, 1, 2, 2, 1, 1, 8, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        nop("t5_cnt", 0, 0, 1);
        nop("t5_wb2", 1, 2, 1);
        nop("t5_nosq", 0, 0, 1);

        // MEM_stall freezes slots; reset clears them
        step("t6_add9",  0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        nop("t6_n0", 0, 0, 1);
        step("t6_frz0",  0, 1, 9, 1, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 1);
        step("t6_frz1",  0, 1, 9, 1, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 1);
        step("t6_frz2",  0, 1, 9, 1, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 1);
        step("t6_rst",   1, 1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 1);
        step("t6_post",  0, 1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check_val("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
